axis_sync_fifo: RTL and testbench
=================================

# axis_sync_fifo

Single-clock AXI-Stream-style FIFO that buffers a valid/ready data stream and sits directly upstream of the skid buffer, feeding its `i_valid`/`i_data` and consuming its `o_ready`. It absorbs bursts from the producer and presents data first-word-fall-through, so the skid buffer sees the head word as soon as it is stored. Occupancy and full/empty flags are exported for monitoring and flow-control decisions.

## Interface
- `DLEN`, 8, data width in bits.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  FIFO can accept a word (`= !o_full`).
- `i_data`  in  `DLEN`  upstream word.
- `o_valid`  out  1  head word valid (`= !o_empty`).
- `i_ready`  in  1  downstream (skid buffer) accepts the head word.
- `o_data`  out  `DLEN`  head word; 0 when empty.
- `o_count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `o_full`  out  1  `o_count == DEPTH`.
- `o_empty`  out  1  `o_count == 0`.

## Operation
- Push: `ihs = i_valid & o_ready`. On push, `mem[wr_ptr] <= i_data` and `wr_ptr` increments.
- Pop: `ohs = o_valid & i_ready`. On pop, `rd_ptr` increments.
- Pointers are `AW+1` bits (`AW = $clog2(DEPTH)`). The low `AW` bits index memory; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- `o_count = wr_ptr - rd_ptr`, computed modulo `2^(AW+1)`. It is derived from the pointers, with no separate counter register.
- `o_data = o_empty ? 0 : mem[rd_ptr[AW-1:0]]`, an asynchronous read of the register array.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Full with `i_ready=1`: `o_ready=0` that cycle, so the pop proceeds and no push occurs. There is no same-cycle pass-through, and `o_ready` rises the next cycle.
- Empty with `i_valid=1`: no bypass. The word is written and `o_valid` rises the next cycle.
- `o_ready` never depends combinationally on `i_ready`, and `o_valid` never depends combinationally on `i_valid`. There are no combinational paths from inputs to handshake outputs.
- Once `o_valid=1`, it holds, and `o_data` holds stable, until a pop occurs (AXI-Stream stability).
- Reset (asserted at any time, including mid-burst):
  - Pointers clear to 0, so `o_count=0`, `o_empty=1`, `o_full=0`, `o_valid=0`, `o_ready=1`, `o_data=0`.
  - Memory contents are not reset; stored words are discarded.
- Deassertion of reset is synchronized externally; the first push is accepted on the first edge after release.

## Timing
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on `o_valid`/`o_data` after edge N.
- Throughput is one push and one pop per cycle sustained at any occupancy 1..`DEPTH-1`.
- `o_ready`, `o_valid`, `o_full`, `o_empty` and `o_count` are functions of registered pointers only.
- `o_data` is a mux off registered state: register array indexed by `rd_ptr`.
- Pointer wrap from `DEPTH-1` to 0 toggles the MSB. `o_count` remains correct across the wrap.

## Structure
- Package `axis_pkg`: default `DLEN` constant, and function `ptr_w(depth)` returning `$clog2(depth)+1`.
- Sub-module `axis_fifo_mem`:
  - `DEPTH`×`DLEN` register array with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`); no reset.
- Top level holds the pointers, flag/count logic, handshakes and the `o_data` zero mux.
- Estimated size: ~150 lines total.

## Test plan
- Reset, then 16 pushes of 0x01..0x10 with `i_ready=0`:
  - `o_count` steps 1..16.
  - `o_full=1` and `o_ready=0` after the 16th push; a 17th word 0xFF is not accepted.
- From full, `i_ready=1` for 16 cycles:
  - `o_data` reads 0x01..0x10 in order.
  - `o_empty=1` and `o_data=0` afterwards, and 0xFF never appears.
- Continuous stream 0x00..0x3F with `i_valid=i_ready=1`:
  - Every word is delivered once and in order.
  - `o_count` holds at 1 after the first cycle, and the pointers wrap four times.
- Full FIFO with `i_valid=1`, `i_ready=1`:
  - That cycle pops 0x01 and pushes nothing.
  - The next cycle `o_ready=1` and `o_count=16` after the push.
- Empty FIFO, single push of 0xA5 at edge N:
  - `o_valid=0` before edge N.
  - `o_valid=1` and `o_data=0xA5` after edge N.
- Randomized `i_valid`/`i_ready` with `rstn` asserted asynchronously mid-stream at occupancy 7:
  - Outputs immediately show the reset values.
  - Post-reset words come out in order, with no stale words.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream FIFO slice.
package axis_pkg;

   localparam int unsigned DLEN_DEF = 8;

   // Pointer width: address bits plus one wrap bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return 32'($clog2(depth)) + 32'd1;
   endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// DEPTH x DLEN register array: one synchronous write port, one asynchronous read port.
module axis_fifo_mem #(
   parameter int unsigned DLEN  = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [DLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [DLEN-1:0] rdata
);

   logic [DLEN-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Flags and count come straight from the registered wrap-bit pointers.
module axis_sync_fifo
   import axis_pkg::*;
#(
   parameter int unsigned DLEN  = DLEN_DEF,
   parameter int unsigned DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [DLEN-1:0]           i_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [DLEN-1:0]           o_data,
   output logic [ptr_w(DEPTH)-1:0]   o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = ptr_w(DEPTH);

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [DLEN-1:0] rdata;
   logic            ihs;
   logic            ohs;

   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign o_count = wr_ptr - rd_ptr;
   assign o_ready = !o_full;
   assign o_valid = !o_empty;

   assign ihs = i_valid & o_ready;
   assign ohs = o_valid & i_ready;

   // Pointer registers; a full FIFO refuses the push even while popping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ihs) wr_ptr <= wr_ptr + PW'(1);
         if (ohs) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   axis_fifo_mem #(
      .DLEN  (DLEN),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (ihs),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (i_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   assign o_data = o_empty ? '0 : rdata;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo: a queue model tracks contents, a negedge
// monitor compares every output against it, directed phases add explicit checks.
module tb_axis_sync_fifo;

   localparam int unsigned DLEN  = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rstn;
   logic            i_valid;
   logic            o_ready;
   logic [DLEN-1:0] i_data;
   logic            o_valid;
   logic            i_ready;
   logic [DLEN-1:0] o_data;
   logic [CW-1:0]   o_count;
   logic            o_full;
   logic            o_empty;

   int passed = 0;
   int total  = 0;

   logic [DLEN-1:0] exp_q [$];
   int              sz;
   bit              do_pop;
   bit              do_push;

   axis_sync_fifo #(
      .DLEN  (DLEN),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_count (o_count),
      .o_full  (o_full),
      .o_empty (o_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a queue of stored words; push is refused whenever the
   // FIFO held DEPTH words before the edge, pop takes the head if any.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q.delete();
      end else begin
         sz      = exp_q.size();
         do_pop  = i_ready && (sz > 0);
         do_push = i_valid && (sz < int'(DEPTH));
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(i_data);
      end
   end

   // Monitor: outputs versus model state, plus delivered-word scoreboard.
   always @(negedge clk) begin
      int n;
      n = exp_q.size();
      check("count", 32'(o_count), 32'(n));
      check("empty", 32'(o_empty), 32'(n == 0));
      check("full", 32'(o_full), 32'(n == int'(DEPTH)));
      check("ready", 32'(o_ready), 32'(n != int'(DEPTH)));
      check("valid", 32'(o_valid), 32'(n != 0));
      if (n == 0) check("data_zero", 32'(o_data), 32'd0);
      else if (i_ready) check("delivered", 32'(o_data), 32'(exp_q[0]));
      else check("head_hold", 32'(o_data), 32'(exp_q[0]));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DLEN-1:0] d, input logic r);
      i_valid = v;
      i_data  = d;
      i_ready = r;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, 32'(o_count), 32'd0);
      check({tag, "_empty"}, 32'(o_empty), 32'd1);
      check({tag, "_full"},  32'(o_full),  32'd0);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
      check({tag, "_data"},  32'(o_data),  32'd0);
   endtask

   initial begin
      bit hit;
      rstn = 1'b0;
      drive(1'b0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #3 rstn = 1'b1;
      check_reset_outputs("rst");
      step();

      // Fill with 0x01..0x10 while downstream stalls, then offer 0xFF.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, DLEN'(i), 1'b0);
         step();
         check("fill_count", 32'(o_count), 32'(i));
      end
      check("fill_full", 32'(o_full), 32'd1);
      check("fill_ready", 32'(o_ready), 32'd0);
      drive(1'b1, 8'hFF, 1'b0);
      step();
      check("ovf_count", 32'(o_count), 32'd16);

      // Drain in order; 0xFF must never surface.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, '0, 1'b1);
         check("drain_data", 32'(o_data), 32'(i));
         step();
      end
      check("drain_empty", 32'(o_empty), 32'd1);
      check("drain_zero", 32'(o_data), 32'd0);

      // Continuous stream through an otherwise empty FIFO, wraps pointers 4x.
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, DLEN'(i), 1'b1);
         if (i > 0) begin
            check("stream_data", 32'(o_data), 32'(i - 1));
            check("stream_count", 32'(o_count), 32'd1);
         end
         step();
      end
      drive(1'b0, '0, 1'b1);
      check("stream_last", 32'(o_data), 32'h3F);
      step();
      check("stream_empty", 32'(o_empty), 32'd1);

      // Full with both handshakes high: pop only, push the next cycle.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, DLEN'(i), 1'b0);
         step();
      end
      drive(1'b1, 8'h77, 1'b1);
      check("fullpp_head", 32'(o_data), 32'h01);
      step();
      check("fullpp_count", 32'(o_count), 32'd15);
      check("fullpp_ready", 32'(o_ready), 32'd1);
      check("fullpp_head2", 32'(o_data), 32'h02);
      drive(1'b1, 8'h77, 1'b0);
      step();
      check("fullpp_refill", 32'(o_count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, '0, 1'b1);
         step();
      end
      check("fullpp_empty", 32'(o_empty), 32'd1);

      // Single word into an empty FIFO appears one edge later.
      drive(1'b1, 8'hA5, 1'b0);
      check("lat_before", 32'(o_valid), 32'd0);
      step();
      check("lat_valid", 32'(o_valid), 32'd1);
      check("lat_data", 32'(o_data), 32'hA5);
      drive(1'b0, '0, 1'b1);
      step();

      // Random traffic, asynchronous reset once occupancy reaches 7.
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         drive($urandom_range(0, 3) != 0, DLEN'($urandom), $urandom_range(0, 2) == 0);
         step();
         if (exp_q.size() == 7) hit = 1'b1;
      end
      check("occ7_reached", 32'(hit), 32'd1);
      drive(1'b1, DLEN'($urandom), 1'b0);
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      check_reset_outputs("post_rst");
      for (int c = 0; c < 300; c++) begin
         drive($urandom_range(0, 1) == 1, DLEN'($urandom), $urandom_range(0, 3) != 0);
         step();
      end
      for (int c = 0; c < int'(DEPTH) + 2; c++) begin
         drive(1'b0, '0, 1'b1);
         step();
      end
      check("final_empty", 32'(o_empty), 32'd1);
      check("final_data", 32'(o_data), 32'd0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
